// File: rtl/mem_arbiter.sv
// Core/VGA arbiter for the shared single-port RAM, plus the PS/2 key register at KBD_ADDR.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention instead of VGA priority.
module mem_arbiter #(
    parameter int                ADDR_W   = 24,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] KBD_ADDR = 24'h3b00,
    parameter int                MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [7:0]        kbd_code,
    input  logic              kbd_strobe
);

    typedef enum logic {
        KBD_IDLE,
        KBD_BREAK
    } kbd_state_t;

    kbd_state_t        state;
    kbd_state_t        state_nxt;
    logic [15:0]       kbd_reg;
    logic [15:0]       kbd_reg_nxt;
    logic [15:0]       kbd_lat;
    logic [7:0]        kbd_make;
    logic [7:0]        kbd_make_nxt;
    logic [15:0]       key_word;
    logic              key_valid;
    logic              kbd_rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              core_wins;
    logic              kbd_hit;
    logic              kbd_wr;
    logic              core_rd;

    assign kbd_hit = (core_addr == KBD_ADDR);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic rr_last;  // 1: core held the most recent grant

    assign core_wins = ~rr_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last <= 1'b1;
        end else if (core_gnt) begin
            rr_last <= 1'b1;
        end else if (vga_gnt) begin
            rr_last <= 1'b0;
        end
    end
`else
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;

    assign core_wins = (wait_cnt == WAIT_LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 4'd0;
        end else if (!core_req || core_gnt) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != 4'hf) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`endif

    // Grants are forced low while reset is asserted
    assign core_gnt = reset_n & core_req & (~vga_req | core_wins);
    assign vga_gnt  = reset_n & vga_req & (~core_req | ~core_wins);

    assign core_rd = core_gnt & ~core_we;
    assign kbd_wr  = core_gnt & core_we & kbd_hit;

    assign ram_we    = core_gnt & core_we & ~kbd_hit;
    assign ram_addr  = core_gnt ? core_addr : (vga_gnt ? vga_addr : addr_q);
    assign ram_wdata = core_gnt ? core_wdata : wdata_q;

    assign core_rdata = !core_rvalid ? '0 :
                        (kbd_rd_q ? DATA_W'(kbd_lat) : ram_rdata);
    assign vga_rdata  = vga_rvalid ? ram_rdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_rvalid <= 1'b0;
            vga_rvalid  <= 1'b0;
            kbd_rd_q    <= 1'b0;
            kbd_lat     <= 16'h0000;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            core_rvalid <= core_rd;
            vga_rvalid  <= vga_gnt;
            kbd_rd_q    <= core_rd & kbd_hit;
            if (core_rd && kbd_hit) begin
                kbd_lat <= kbd_reg;
            end
            if (core_gnt || vga_gnt) begin
                addr_q <= ram_addr;
            end
            if (core_gnt) begin
                wdata_q <= core_wdata;
            end
        end
    end

    always_comb begin
        key_valid = 1'b1;
        key_word  = 16'h0000;
        case (kbd_code)
            8'h1b:   key_word = 16'hff53;
            8'h1c:   key_word = 16'hff41;
            8'h1d:   key_word = 16'hff57;
            8'h23:   key_word = 16'hff44;
            8'h75:   key_word = 16'hff2f;
            8'h72:   key_word = 16'hff5c;
            default: key_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= KBD_IDLE;
            kbd_reg  <= 16'h0000;
            kbd_make <= 8'h00;
        end else begin
            state    <= state_nxt;
            kbd_reg  <= kbd_reg_nxt;
            kbd_make <= kbd_make_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (kbd_strobe) begin
            case (state)
                KBD_IDLE: begin
                    if (kbd_code == 8'hf0) begin
                        state_nxt = KBD_BREAK;
                    end
                end
                KBD_BREAK: state_nxt = KBD_IDLE;
                default:   state_nxt = KBD_IDLE;
            endcase
        end
    end

    // A strobe in the same cycle as a core clear takes precedence
    always_comb begin
        kbd_reg_nxt  = kbd_reg;
        kbd_make_nxt = kbd_make;
        if (kbd_strobe) begin
            if (state == KBD_IDLE && key_valid) begin
                kbd_reg_nxt  = key_word;
                kbd_make_nxt = kbd_code;
            end else if (state == KBD_BREAK && kbd_code == kbd_make) begin
                kbd_reg_nxt  = 16'h0000;
                kbd_make_nxt = 8'h00;
            end
        end else if (kbd_wr) begin
            kbd_reg_nxt  = 16'h0000;
            kbd_make_nxt = 8'h00;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RAM path, arbitration, keyboard register, reset.
// Expects the default build unless MEM_ARB_ROUND_ROBIN_EN is defined for both.
module tb_mem_arbiter;

    localparam logic [23:0] KBD = 24'h3b00;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [23:0] core_addr = '0;
    logic [15:0] core_wdata = '0;
    logic        core_gnt;
    logic        core_rvalid;
    logic [15:0] core_rdata;
    logic        vga_req = 1'b0;
    logic [23:0] vga_addr = '0;
    logic        vga_gnt;
    logic        vga_rvalid;
    logic [15:0] vga_rdata;
    logic        ram_we;
    logic [23:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [7:0]  kbd_code = '0;
    logic        kbd_strobe = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:255];

    mem_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_rvalid(core_rvalid),
        .core_rdata (core_rdata),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_gnt    (vga_gnt),
        .vga_rvalid (vga_rvalid),
        .vga_rdata  (vga_rdata),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .kbd_code   (kbd_code),
        .kbd_strobe (kbd_strobe)
    );

    always #5 clk = ~clk;

    // Write-first synchronous RAM
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr[7:0]] <= ram_wdata;
            ram_rdata          <= ram_wdata;
        end else begin
            ram_rdata <= mem[ram_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic c_set(input logic r, input logic w,
                         input logic [23:0] a, input logic [15:0] d);
        core_req   = r;
        core_we    = w;
        core_addr  = a;
        core_wdata = d;
    endtask

    task automatic strobe(input logic [7:0] c);
        @(negedge clk);
        kbd_code   = c;
        kbd_strobe = 1'b1;
        @(posedge clk);
        #1;
        kbd_strobe = 1'b0;
    endtask

    task automatic core_write(input logic [23:0] a, input logic [15:0] d,
                              input logic exp_we);
        @(negedge clk);
        c_set(1'b1, 1'b1, a, d);
        #2;
        chk("wr_gnt", 32'(core_gnt), 32'd1);
        chk("wr_ram_we", 32'(ram_we), 32'(exp_we));
        @(negedge clk);
        c_set(1'b0, 1'b0, a, 16'h0);
    endtask

    task automatic rd_kbd(input string tag, input logic [15:0] exp);
        @(negedge clk);
        c_set(1'b1, 1'b0, KBD, 16'h0);
        #2;
        chk("kbd_rd_gnt", 32'(core_gnt), 32'd1);
        chk("kbd_rd_ram_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        c_set(1'b0, 1'b0, 24'h0, 16'h0);
        #2;
        chk("kbd_rd_rvalid", 32'(core_rvalid), 32'd1);
        chk(tag, 32'(core_rdata), 32'(exp));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_core_gnt"}, 32'(core_gnt), 32'd0);
        chk({tag, "_vga_gnt"}, 32'(vga_gnt), 32'd0);
        chk({tag, "_core_rvalid"}, 32'(core_rvalid), 32'd0);
        chk({tag, "_vga_rvalid"}, 32'(vga_rvalid), 32'd0);
        chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
        chk({tag, "_core_rdata"}, 32'(core_rdata), 32'd0);
        chk({tag, "_vga_rdata"}, 32'(vga_rdata), 32'd0);
    endtask

    initial begin
        logic exp_core;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #2;
        chk_reset_outs("rst");
        @(negedge clk);
        reset_n = 1'b1;

        // Preload RAM through the core port
        core_write(24'h000010, 16'h1234, 1'b1);
        core_write(24'h000030, 16'h5a5a, 1'b1);

        // Lone core read
        @(negedge clk);
        c_set(1'b1, 1'b0, 24'h000010, 16'h0);
        #2;
        chk("rd_core_gnt", 32'(core_gnt), 32'd1);
        chk("rd_vga_gnt", 32'(vga_gnt), 32'd0);
        chk("rd_ram_addr", 32'(ram_addr), 32'h10);
        chk("rd_ram_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        c_set(1'b0, 1'b0, 24'h0, 16'h0);
        #2;
        chk("rd_rvalid", 32'(core_rvalid), 32'd1);
        chk("rd_rdata", 32'(core_rdata), 32'h1234);
        chk("rd_vga_rvalid", 32'(vga_rvalid), 32'd0);
        chk("rd_addr_hold", 32'(ram_addr), 32'h10);
        @(negedge clk);
        #2;
        chk("rd_rvalid_drop", 32'(core_rvalid), 32'd0);

        // Write then read same address
        @(negedge clk);
        c_set(1'b1, 1'b1, 24'h000020, 16'hbeef);
        #2;
        chk("wf_ram_we", 32'(ram_we), 32'd1);
        chk("wf_ram_wdata", 32'(ram_wdata), 32'hbeef);
        chk("wf_ram_addr", 32'(ram_addr), 32'h20);
        @(negedge clk);
        c_set(1'b1, 1'b0, 24'h000020, 16'h0);
        #2;
        chk("wf_rd_gnt", 32'(core_gnt), 32'd1);
        @(negedge clk);
        c_set(1'b0, 1'b0, 24'h0, 16'h0);
        #2;
        chk("wf_rvalid", 32'(core_rvalid), 32'd1);
        chk("wf_rdata", 32'(core_rdata), 32'hbeef);

        // Back-to-back VGA then core reads
        @(negedge clk);
        vga_req  = 1'b1;
        vga_addr = 24'h000030;
        #2;
        chk("b2b_vga_gnt", 32'(vga_gnt), 32'd1);
        chk("b2b_vga_addr", 32'(ram_addr), 32'h30);
        @(negedge clk);
        vga_req = 1'b0;
        c_set(1'b1, 1'b0, 24'h000010, 16'h0);
        #2;
        chk("b2b_core_gnt", 32'(core_gnt), 32'd1);
        chk("b2b_vga_rvalid", 32'(vga_rvalid), 32'd1);
        chk("b2b_vga_rdata", 32'(vga_rdata), 32'h5a5a);
        chk("b2b_core_rv0", 32'(core_rvalid), 32'd0);
        @(negedge clk);
        c_set(1'b0, 1'b0, 24'h0, 16'h0);
        #2;
        chk("b2b_core_rvalid", 32'(core_rvalid), 32'd1);
        chk("b2b_core_rdata", 32'(core_rdata), 32'h1234);
        chk("b2b_vga_rv0", 32'(vga_rvalid), 32'd0);

        // Continuous contention
        @(negedge clk);
        c_set(1'b1, 1'b0, 24'h000040, 16'h0);
        vga_req  = 1'b1;
        vga_addr = 24'h000050;
        for (int k = 0; k < 32; k++) begin
            if (k != 0) @(negedge clk);
            #2;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_core = (k % 2) == 1;
`else
            exp_core = (k % 16) == 15;
`endif
            chk($sformatf("arb_core_gnt_%0d", k), 32'(core_gnt), 32'(exp_core));
            chk($sformatf("arb_vga_gnt_%0d", k), 32'(vga_gnt), 32'(!exp_core));
        end
        @(negedge clk);
        c_set(1'b0, 1'b0, 24'h0, 16'h0);
        vga_req = 1'b0;
        @(negedge clk);

        // Keyboard make / break
        strobe(8'h1c);
        rd_kbd("kbd_make_1c", 16'hff41);
        strobe(8'hf0);
        strobe(8'h1c);
        rd_kbd("kbd_break_1c", 16'h0000);
        strobe(8'h1c);
        strobe(8'hf0);
        strobe(8'h1b);
        rd_kbd("kbd_bad_break", 16'hff41);
        strobe(8'h1b);
        rd_kbd("kbd_idle_again", 16'hff53);
        strobe(8'h2a);
        rd_kbd("kbd_unmapped", 16'hff53);
        strobe(8'he0);
        strobe(8'h1c);
        rd_kbd("kbd_e0_ignored", 16'hff41);

        // Strobe beats a same-cycle core clear
        @(negedge clk);
        c_set(1'b1, 1'b1, KBD, 16'h1111);
        kbd_code   = 8'h75;
        kbd_strobe = 1'b1;
        #2;
        chk("kbd_same_gnt", 32'(core_gnt), 32'd1);
        chk("kbd_same_ram_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        kbd_strobe = 1'b0;
        c_set(1'b0, 1'b0, 24'h0, 16'h0);
        rd_kbd("kbd_same_cycle", 16'hff2f);
        core_write(KBD, 16'h2222, 1'b0);
        rd_kbd("kbd_clear", 16'h0000);

        // Reset during an outstanding read
        strobe(8'h23);
        rd_kbd("kbd_pre_rst", 16'hff44);
        @(negedge clk);
        c_set(1'b1, 1'b0, 24'h000010, 16'h0);
        #2;
        chk("rst_rd_gnt", 32'(core_gnt), 32'd1);
        #1;
        reset_n = 1'b0;
        c_set(1'b0, 1'b0, 24'h0, 16'h0);
        #1;
        chk_reset_outs("rst_mid");
        @(negedge clk);
        reset_n = 1'b1;
        #2;
        chk_reset_outs("rst_after");
        @(negedge clk);
        #2;
        chk("rst_no_rvalid", 32'(core_rvalid), 32'd0);
        rd_kbd("kbd_after_rst", 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
